// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: scans the screen-clipped bounding box with incremental
// edge functions and streams covered pixels over a valid/ready handshake.
module triangle_rasterizer #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int CW       = 16,
   parameter int EW       = 36
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          data_ready,
   input  logic [CW-1:0] x1,
   input  logic [CW-1:0] y1,
   input  logic [CW-1:0] x2,
   input  logic [CW-1:0] y2,
   input  logic [CW-1:0] x3,
   input  logic [CW-1:0] y3,
   input  logic [7:0]    TexNum,
   output logic          next_triangle,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic [7:0]    pix_tex,
   output logic          busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_EINIT = 3'd2;
   localparam logic [2:0] S_SCAN  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [CW-1:0] LP_XMAX = CW'(SCREEN_W - 1);
   localparam logic [CW-1:0] LP_YMAX = CW'(SCREEN_H - 1);

   logic [2:0]             r_state;
   logic [CW-1:0]          r_vx [3];
   logic [CW-1:0]          r_vy [3];
   logic [7:0]             r_tex;
   logic [CW-1:0]          r_minx, r_miny, r_maxx, r_maxy;
   logic [CW-1:0]          r_cx, r_cy;
   logic signed [CW:0]     r_dx [3];
   logic signed [CW:0]     r_dy [3];
   logic signed [EW-1:0]   r_row [3];
   logic signed [EW-1:0]   r_col [3];

   logic signed [CW:0]     w_dx [3];
   logic signed [CW:0]     w_dy [3];
   logic signed [EW-1:0]   w_e0 [3];
   logic signed [EW-1:0]   w_area;
   logic [CW-1:0]          w_minx, w_miny, w_maxx, w_maxy;
   logic [2:0]             w_pos, w_neg;
   logic                   w_in, w_adv, w_xend, w_last;

   function automatic logic [CW-1:0] f_min3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [CW-1:0] f_max3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic logic signed [CW:0] f_sub(input logic [CW-1:0] a, b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   function automatic logic signed [EW-1:0] f_sx(input logic signed [CW:0] v);
      return {{(EW-CW-1){v[CW]}}, v};
   endfunction

   // E_ab(p) = dx*(py-ya) - dy*(px-xa), computed at full EW width
   function automatic logic signed [EW-1:0] f_edge(
      input logic signed [CW:0] dx, dy,
      input logic [CW-1:0] px, py, xa, ya);
      return f_sx(dx) * f_sx(f_sub(py, ya)) - f_sx(dy) * f_sx(f_sub(px, xa));
   endfunction

   assign w_dx[0] = f_sub(r_vx[1], r_vx[0]);
   assign w_dx[1] = f_sub(r_vx[2], r_vx[1]);
   assign w_dx[2] = f_sub(r_vx[0], r_vx[2]);
   assign w_dy[0] = f_sub(r_vy[1], r_vy[0]);
   assign w_dy[1] = f_sub(r_vy[2], r_vy[1]);
   assign w_dy[2] = f_sub(r_vy[0], r_vy[2]);

   assign w_area = f_edge(w_dx[0], w_dy[0], r_vx[2], r_vy[2], r_vx[0], r_vy[0]);
   assign w_minx = f_min3(r_vx[0], r_vx[1], r_vx[2]);
   assign w_miny = f_min3(r_vy[0], r_vy[1], r_vy[2]);
   assign w_maxx = f_max3(r_vx[0], r_vx[1], r_vx[2]);
   assign w_maxy = f_max3(r_vy[0], r_vy[1], r_vy[2]);

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         w_e0[k]  = f_edge(r_dx[k], r_dy[k], r_minx, r_miny, r_vx[k], r_vy[k]);
         w_pos[k] = !r_col[k][EW-1];
         w_neg[k] = r_col[k][EW-1] || (r_col[k] == '0);
      end
   end

   assign w_in   = (&w_pos) || (&w_neg);
   assign w_adv  = !pix_valid || pix_ready;
   assign w_xend = (r_cx == r_maxx);
   assign w_last = w_xend && (r_cy == r_maxy);
   assign busy   = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         next_triangle <= 1'b0;
         pix_valid     <= 1'b0;
         pix_x         <= '0;
         pix_y         <= '0;
         pix_tex       <= '0;
         r_tex         <= '0;
         r_minx        <= '0;
         r_miny        <= '0;
         r_maxx        <= '0;
         r_maxy        <= '0;
         r_cx          <= '0;
         r_cy          <= '0;
         for (int k = 0; k < 3; k++) begin
            r_vx[k]  <= '0;
            r_vy[k]  <= '0;
            r_dx[k]  <= '0;
            r_dy[k]  <= '0;
            r_row[k] <= '0;
            r_col[k] <= '0;
         end
      end else begin
         next_triangle <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (data_ready) begin
                  r_vx[0] <= x1;
                  r_vy[0] <= y1;
                  r_vx[1] <= x2;
                  r_vy[1] <= y2;
                  r_vx[2] <= x3;
                  r_vy[2] <= y3;
                  r_tex   <= TexNum;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_minx <= w_minx;
               r_miny <= w_miny;
               r_maxx <= (w_maxx > LP_XMAX) ? LP_XMAX : w_maxx;
               r_maxy <= (w_maxy > LP_YMAX) ? LP_YMAX : w_maxy;
               for (int k = 0; k < 3; k++) begin
                  r_dx[k] <= w_dx[k];
                  r_dy[k] <= w_dy[k];
               end
               if (w_minx > LP_XMAX || w_miny > LP_YMAX || w_area == '0)
                  r_state <= S_DONE;
               else
                  r_state <= S_EINIT;
            end
            S_EINIT: begin
               for (int k = 0; k < 3; k++) begin
                  r_row[k] <= w_e0[k];
                  r_col[k] <= w_e0[k];
               end
               r_cx    <= r_minx;
               r_cy    <= r_miny;
               r_state <= S_SCAN;
            end
            S_SCAN: begin
               if (w_adv) begin
                  pix_valid <= w_in;
                  if (w_in) begin
                     pix_x   <= r_cx;
                     pix_y   <= r_cy;
                     pix_tex <= r_tex;
                  end
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else if (!w_xend) begin
                     r_cx <= r_cx + 1'b1;
                     for (int k = 0; k < 3; k++)
                        r_col[k] <= r_col[k] - f_sx(r_dy[k]);
                  end else begin
                     r_cx <= r_minx;
                     r_cy <= r_cy + 1'b1;
                     for (int k = 0; k < 3; k++) begin
                        r_row[k] <= r_row[k] + f_sx(r_dx[k]);
                        r_col[k] <= r_row[k] + f_sx(r_dx[k]);
                     end
                  end
               end
            end
            S_DONE: begin
               if (w_adv) begin
                  pix_valid     <= 1'b0;
                  next_triangle <= 1'b1;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed bench for triangle_rasterizer: pixel lists, latency,
// stall stability, clipping, degenerate input and mid-scan reset.
module tb_triangle_rasterizer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        data_ready = 1'b0;
   logic [15:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0;
   logic [7:0]  TexNum = '0;
   logic        next_triangle, pix_valid, busy;
   logic        pix_ready = 1'b1;
   logic [15:0] pix_x, pix_y;
   logic [7:0]  pix_tex;

   triangle_rasterizer dut (
      .clk(clk), .reset(reset), .data_ready(data_ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .TexNum(TexNum), .next_triangle(next_triangle),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_tex(pix_tex), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int c0 = 0;
   int first_lat = -1;
   int pulse_lat = -1;
   int pulses = 0;
   int ready_mode = 0;
   int rcnt = 0;
   logic        stalled = 1'b0;
   logic [15:0] sx, sy;
   logic [7:0]  st;
   logic [15:0] gx_q[$], gy_q[$];
   logic [7:0]  gt_q[$];
   logic [15:0] ex_q[$], ey_q[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (stalled && !reset) begin
         check("stall_valid", 32'(pix_valid), 1);
         check("stall_x", 32'(pix_x), 32'(sx));
         check("stall_y", 32'(pix_y), 32'(sy));
         check("stall_tex", 32'(pix_tex), 32'(st));
      end
      if (ready_mode == 0) pix_ready = 1'b1;
      else pix_ready = (rcnt % 3 == 0);
      rcnt++;
      if (pix_valid && pix_ready) begin
         gx_q.push_back(pix_x);
         gy_q.push_back(pix_y);
         gt_q.push_back(pix_tex);
      end
      stalled = pix_valid && !pix_ready;
      sx = pix_x;
      sy = pix_y;
      st = pix_tex;
      if (pix_valid && first_lat < 0) first_lat = cyc - c0;
      if (next_triangle) begin
         pulses++;
         pulse_lat = cyc - c0;
      end
   end

   task automatic start_tri(input logic [15:0] a, b, c, d, e, f,
                            input logic [7:0] t);
      @(negedge clk);
      gx_q.delete();
      gy_q.delete();
      gt_q.delete();
      first_lat = -1;
      pulse_lat = -1;
      pulses = 0;
      x1 = a; y1 = b; x2 = c; y2 = d; x3 = e; y3 = f;
      TexNum = t;
      data_ready = 1'b1;
      c0 = cyc;
      @(negedge clk);
      data_ready = 1'b0;
   endtask

   task automatic run_tri(input logic [15:0] a, b, c, d, e, f,
                          input logic [7:0] t);
      start_tri(a, b, c, d, e, f, t);
      for (int i = 0; i < 400 && pulses == 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("pulse_count", 32'(pulses), 1);
   endtask

   task automatic cmp_list(input string tag, input logic [7:0] t);
      check({tag, "_count"}, 32'(gx_q.size()), 32'(ex_q.size()));
      for (int i = 0; i < ex_q.size() && i < gx_q.size(); i++) begin
         check({tag, "_x"}, 32'(gx_q[i]), 32'(ex_q[i]));
         check({tag, "_y"}, 32'(gy_q[i]), 32'(ey_q[i]));
         check({tag, "_tex"}, 32'(gt_q[i]), 32'(t));
      end
   endtask

   task automatic exp_t1();
      ex_q.delete();
      ey_q.delete();
      for (int y = 0; y <= 3; y++)
         for (int x = 0; x <= 3 - y; x++) begin
            ex_q.push_back(16'(x));
            ey_q.push_back(16'(y));
         end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(pix_valid), 0);
      check("rst_next", 32'(next_triangle), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_x", 32'(pix_x), 0);
      check("rst_tex", 32'(pix_tex), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // T1
      exp_t1();
      run_tri(0, 0, 3, 0, 0, 3, 5);
      check("t1_lat", 32'(first_lat), 4);
      cmp_list("t1", 5);

      // T2: opposite winding
      run_tri(0, 0, 0, 3, 3, 0, 9);
      cmp_list("t2", 9);

      // T3: collinear
      run_tri(0, 0, 2, 2, 4, 4, 1);
      check("t3_pix", 32'(gx_q.size()), 0);
      check("t3_pulse_lat", 32'(pulse_lat), 3);

      // T4: right-edge clipping
      ex_q.delete();
      ey_q.delete();
      for (int y = 0; y <= 3; y++)
         for (int x = 636; x <= 639; x++) begin
            ex_q.push_back(16'(x));
            ey_q.push_back(16'(y));
         end
      ex_q.push_back(16'd636);
      ey_q.push_back(16'd4);
      run_tri(636, 0, 700, 0, 636, 4, 3);
      cmp_list("t4", 3);

      // T5: back-pressure
      exp_t1();
      ready_mode = 1;
      run_tri(0, 0, 3, 0, 0, 3, 5);
      cmp_list("t5", 5);
      ready_mode = 0;

      // T6: reset mid-scan
      start_tri(0, 0, 3, 0, 0, 3, 7);
      repeat (5) @(negedge clk);
      check("t6_busy_pre", 32'(busy), 1);
      pulses = 0;
      reset = 1'b1;
      #1;
      check("t6_valid", 32'(pix_valid), 0);
      check("t6_x", 32'(pix_x), 0);
      check("t6_y", 32'(pix_y), 0);
      check("t6_tex", 32'(pix_tex), 0);
      check("t6_busy", 32'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("t6_no_pulse", 32'(pulses), 0);
      exp_t1();
      run_tri(0, 0, 3, 0, 0, 3, 7);
      check("t6_lat", 32'(first_lat), 4);
      cmp_list("t6", 7);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
